// File: rtl/dffre_deser_pkg.sv
// ---------------------------------------------------------------------------
// dffre_deser_pkg : shared types and helpers for the serial-to-parallel deserializer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dffre_deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dffre_deser.sv
// ---------------------------------------------------------------------------
// dffre_deser : packs a qualified serial bit stream into WIDTH-bit words behind a valid/ready output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dffre_deser
  import dffre_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        i_Reset,
  input  logic                        i_Enable,
  input  logic                        i_D,
  input  logic                        i_Ready,
  output logic [WIDTH-1:0]            o_Data,
  output logic                        o_Valid,
  output logic                        o_Overflow,
  output logic [cnt_width(WIDTH)-1:0] o_Count
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_t   state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;

  logic             free_d;
  logic [WIDTH-1:0] word_d;

  assign free_d = !valid_q || i_Ready;
  assign word_d = {sr_q[WIDTH-2:0], i_D};

  always_ff @(posedge clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= FILL;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // A consume clears valid; any load below in the same cycle re-sets it.
      if (valid_q && i_Ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (i_Enable) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
              if (free_d) begin
                data_q  <= word_d;
                valid_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                sr_q    <= word_d;
                cnt_q   <= CW'(WIDTH);
                state_q <= FULL;
              end
            end else begin
              sr_q  <= word_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        FULL: begin
          if (free_d) begin
            data_q  <= sr_q;
            valid_q <= 1'b1;
            state_q <= FILL;
            if (i_Enable) begin
              sr_q[0] <= i_D;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end else if (i_Enable) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_Overflow = ovf_q;
  assign o_Count    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dffre_deser.sv
// ---------------------------------------------------------------------------
// tb_dffre_deser : self-checking bench for dffre_deser (WIDTH = 8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dffre_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         i_Reset, i_Enable, i_D, i_Ready;
  logic [W-1:0] o_Data;
  logic         o_Valid, o_Overflow;
  logic [3:0]   o_Count;

  dffre_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .i_Reset    (i_Reset),
    .i_Enable   (i_Enable),
    .i_D        (i_D),
    .i_Ready    (i_Ready),
    .o_Data     (o_Data),
    .o_Valid    (o_Valid),
    .o_Overflow (o_Overflow),
    .o_Count    (o_Count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1; i_Enable = 1'b0; i_D = 1'b0; i_Ready = 1'b0;
    cyc();
    i_Reset = 1'b0;
  endtask

  task automatic drive(input logic en, input logic d, input logic rdy);
    i_Enable = en; i_D = d; i_Ready = rdy;
    cyc();
  endtask

  // Reference model: a list of held bits plus an output slot
  bit         mq[$];
  logic [W-1:0] m_data;
  bit         m_valid, m_ovf;

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] v = '0;
    foreach (mq[i]) v = {v[W-2:0], logic'(mq[i])};
    return v;
  endfunction

  task automatic m_reset();
    mq.delete(); m_data = '0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic m_step(input bit en, input bit d, input bit rdy);
    bit slot_open = !m_valid || rdy;
    bit loaded = 0;
    if (mq.size() == W) begin
      if (slot_open) begin
        m_data = pack_bits(); loaded = 1; mq.delete();
        if (en) mq.push_back(d);
      end else if (en) begin
        m_ovf = 1;
      end
    end else if (en) begin
      mq.push_back(d);
      if (mq.size() == W && slot_open) begin
        m_data = pack_bits(); loaded = 1; mq.delete();
      end
    end
    if (loaded) m_valid = 1;
    else if (m_valid && rdy) m_valid = 0;
  endtask

  typedef struct {
    logic       rst, en, d, rdy;
    logic [7:0] data;
    logic       valid, ovf;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, en, d, rdy, input logic [7:0] data,
                     input logic valid, ovf, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.d = d; v.rdy = rdy;
    v.data = data; v.valid = valid; v.ovf = ovf; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] w0, w1;
    logic [7:0] words[8];
    int         seen;

    do_reset();
    chk("reset_valid", 32'(o_Valid), 0);
    chk("reset_data",  32'(o_Data), 0);
    chk("reset_cnt",   32'(o_Count), 0);
    chk("reset_ovf",   32'(o_Overflow), 0);

    // Scenario 1: reset mid-word, then 8'hB2
    pat = 8'hB2;
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 1, 8'h00, 0, 0, 4'(k));
    add(1, 0, 0, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, pat[7-i], 1, 8'h00, 0, 0, 4'(i + 1));
    add(0, 1, pat[0], 1, 8'hB2, 1, 0, 0);
    add(0, 0, 0, 1, 8'hB2, 0, 0, 0);
    foreach (tbl[i]) begin
      i_Reset = tbl[i].rst;
      drive(tbl[i].en, tbl[i].d, tbl[i].rdy);
      chk("tbl_valid", 32'(o_Valid),    32'(tbl[i].valid));
      chk("tbl_data",  32'(o_Data),     32'(tbl[i].data));
      chk("tbl_cnt",   32'(o_Count),    32'(tbl[i].cnt));
      chk("tbl_ovf",   32'(o_Overflow), 32'(tbl[i].ovf));
    end
    i_Reset = 1'b0;

    // Scenario 2: enable gating, random i_D on idle cycles
    do_reset();
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) drive(1, pat[7 - k/2], 1);
      else            drive(0, 1'($urandom), 1);
      chk("gate_cnt", 32'(o_Count), 32'(((k + 2) / 2) % 8));
      chk("gate_valid", 32'(o_Valid), 32'(k == 14));
      if (o_Valid) begin
        seen++;
        chk("gate_data", 32'(o_Data), 32'h B2);
      end
    end
    chk("gate_words", 32'(seen), 1);

    // Scenario 3: 64-bit stream, ready held high
    do_reset();
    foreach (words[i]) words[i] = 8'($urandom);
    for (int k = 0; k < 64; k++) begin
      drive(1, words[k/8][7 - k%8], 1);
      chk("stream_valid", 32'(o_Valid), 32'(k % 8 == 7));
      if (k % 8 == 7) chk("stream_data", 32'(o_Data), 32'(words[k/8]));
    end
    chk("stream_ovf", 32'(o_Overflow), 0);

    // Scenario 4: backpressure, then FULL exit with a concurrent bit
    do_reset();
    w0 = 8'($urandom); w1 = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      drive(1, (k < 8) ? w0[7-k] : w1[15-k], 0);
      if (k == 7) chk("bp_first_valid", 32'(o_Valid), 1);
    end
    chk("bp_valid", 32'(o_Valid), 1);
    chk("bp_data",  32'(o_Data), 32'(w0));
    chk("bp_cnt",   32'(o_Count), 8);
    drive(1, 1, 1);
    chk("bp_exit_data",  32'(o_Data), 32'(w1));
    chk("bp_exit_valid", 32'(o_Valid), 1);
    chk("bp_exit_cnt",   32'(o_Count), 1);
    chk("bp_exit_ovf",   32'(o_Overflow), 0);

    // Scenario 5: 17 bits against a stalled sink
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, (k < 8) ? w0[7-k] : (k < 16) ? w1[15-k] : 1'b1, 0);
      chk("ovf_rise", 32'(o_Overflow), 32'(k == 16));
    end
    chk("ovf_cnt",  32'(o_Count), 8);
    chk("ovf_w0",   32'(o_Data), 32'(w0));
    drive(0, 0, 1);
    chk("ovf_w1",      32'(o_Data), 32'(w1));
    chk("ovf_w1_valid", 32'(o_Valid), 1);
    chk("ovf_cnt_after", 32'(o_Count), 0);
    drive(0, 0, 1);
    chk("ovf_drain_valid", 32'(o_Valid), 0);
    chk("ovf_sticky", 32'(o_Overflow), 1);

    // Scenario 6: 1000 random cycles against the reference model
    do_reset();
    m_reset();
    for (int k = 0; k < 1000; k++) begin
      bit en, d, rdy;
      en  = ($urandom_range(3) != 0);
      d   = 1'($urandom);
      rdy = ($urandom_range(2) == 0);
      drive(en, d, rdy);
      m_step(en, d, rdy);
      chk("rnd_valid", 32'(o_Valid),    32'(m_valid));
      chk("rnd_data",  32'(o_Data),     32'(m_data));
      chk("rnd_cnt",   32'(o_Count),    32'(mq.size()));
      chk("rnd_ovf",   32'(o_Overflow), 32'(m_ovf));
      if (k == 600) begin
        do_reset();
        m_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
